signed_or_unsigned_div: RTL

SIGNED_OR_UNSIGNED_DIV -- requirements
Module: signed_or_unsigned_div

---
 rtl/signed_or_unsigned_div.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/signed_or_unsigned_div.sv
// Sequential restoring divider for n-bit signed (two's complement) or unsigned operands.
// Latency: result valid exactly n+1 rising edges after the accepting edge; one operation in flight.
// Backpressure: arg_rdy is high only when idle; a result is held until res_rdy accepts it.

module signed_or_unsigned_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  // Counter runs 0..n: steps 0..n-1 produce quotient bits, step n applies the sign fix-up.
  localparam int              CW        = $clog2(n + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(n);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Captured operands and mode for the operation in flight.
  logic [n-1:0]  a_q,     a_d;
  logic [n-1:0]  b_q,     b_d;
  logic          sdiv_q,  sdiv_d;

  // Partial remainder and the dividend/quotient shift register.
  logic [n-1:0]  pr_q,    pr_d;
  logic [n-1:0]  qt_q,    qt_d;

  // Presented result, kept until the next operation completes.
  logic [n-1:0]  quot_q,  quot_d;
  logic [n-1:0]  rem_q,   rem_d;
  logic          dbz_q,   dbz_d;

  // Operand magnitudes are formed one bit wider than the operands so that
  // negating the most negative value cannot overflow.
  logic [n:0]    a_ext, b_ext;
  logic [n:0]    mag_a, mag_b;

  // One restoring step.
  logic [n-1:0]  dvd;
  logic [n-1:0]  pr_cur;
  logic [n:0]    shifted;
  logic [n+1:0]  diff;
  logic          q_bit;
  logic [n-1:0]  pr_step;
  logic [n-1:0]  qt_step;

  // Sign fix-up and divide-by-zero override.
  logic          b_zero;
  logic          q_neg;
  logic          r_neg;
  logic [n-1:0]  quot_fix;
  logic [n-1:0]  rem_fix;

  // The magnitude of an n-bit operand never exceeds 2^n-1, so mag_a's top bit
  // is always clear; diff[n] is clear whenever the subtraction is kept.
  logic          unused_msbs;
  assign unused_msbs = ^{mag_a[n], diff[n]};

  // Operand magnitudes: sign-extend only in signed mode, then negate if negative.
  always_comb begin
    a_ext = {sdiv_q & a_q[n-1], a_q};
    b_ext = {sdiv_q & b_q[n-1], b_q};
    mag_a = a_ext[n] ? -a_ext : a_ext;
    mag_b = b_ext[n] ? -b_ext : b_ext;
  end

  // Shift in the next dividend bit, trial-subtract the divisor, keep it if no borrow.
  always_comb begin
    dvd     = (cnt_q == '0) ? mag_a[n-1:0] : qt_q;
    pr_cur  = (cnt_q == '0) ? '0           : pr_q;
    shifted = {pr_cur, dvd[n-1]};
    diff    = {1'b0, shifted} - {1'b0, mag_b};
    q_bit   = ~diff[n+1];
    pr_step = q_bit ? diff[n-1:0] : shifted[n-1:0];
    qt_step = {dvd[n-2:0], q_bit};
  end

  // Quotient is negative when the operand signs differ; remainder follows the dividend.
  always_comb begin
    b_zero   = (b_q == '0);
    q_neg    = sdiv_q & (a_q[n-1] ^ b_q[n-1]);
    r_neg    = sdiv_q & a_q[n-1];
    quot_fix = b_zero ? '1  : (q_neg ? -qt_q : qt_q);
    rem_fix  = b_zero ? a_q : (r_neg ? -pr_q : pr_q);
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sdiv_d  = sdiv_q;
    pr_d    = pr_q;
    qt_d    = qt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    arg_rdy = 1'b0;
    res_vld = 1'b0;

    case (state_q)
      IDLE: begin
        arg_rdy = 1'b1;
        if (arg_vld) begin
          a_d     = a;
          b_d     = b;
          sdiv_d  = signed_div;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q == LAST_STEP) begin
          quot_d  = quot_fix;
          rem_d   = rem_fix;
          dbz_d   = b_zero;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          pr_d  = pr_step;
          qt_d  = qt_step;
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        res_vld = 1'b1;
        if (res_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sdiv_q  <= 1'b0;
      pr_q    <= '0;
      qt_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sdiv_q  <= sdiv_d;
      pr_q    <= pr_d;
      qt_q    <= qt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule
